// File: rtl/uart_tx_serializer.sv
// UART transmit engine: pops 9-bit words (data + parity) from a registered-read FIFO
// and serialises start, 8 data bits LSB-first, parity and stop bit(s) onto tx.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_SRC   = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tx_enable,
  input  logic       fifo_empty,
  input  logic [8:0] fifo_dout,
  output logic       fifo_rd_en,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int              CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRE   = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic             STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, PARITY, STOP} state_t;

  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic             stop_cnt;
  logic [7:0]       shift_reg;
  logic             par_bit;
  logic             wrap;

  function automatic logic frame_parity(input logic [8:0] word);
    if (PARITY_SRC != 0) return ^word[7:0];
    else                 return word[8];
  endfunction

  assign wrap = (baud_cnt == CNT_LAST);
  assign busy = (state != IDLE);

  // Gated by reset_n so no pop can be requested while reset is held.
  assign fifo_rd_en = reset_n && (state == IDLE) && tx_enable && !fifo_empty;

  always_ff @(posedge clk) begin
    if (state == LOAD) begin
      shift_reg <= fifo_dout[7:0];
      par_bit   <= frame_parity(fifo_dout);
    end else if (state == DATA && wrap) begin
      shift_reg <= {1'b0, shift_reg[7:1]};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      tx         <= 1'b1;
      frame_done <= 1'b0;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      stop_cnt   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (state == IDLE || state == LOAD || wrap) baud_cnt <= '0;
      else                                        baud_cnt <= baud_cnt + CNT_W'(1);

      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (fifo_rd_en) state <= LOAD;
        end
        LOAD: begin
          tx    <= 1'b0;
          state <= START;
        end
        START: begin
          if (wrap) begin
            tx      <= shift_reg[0];
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          // shift_reg shifts on this same edge, so [1] is the bit that follows.
          if (wrap) begin
            if (bit_idx == 3'd7) begin
              tx    <= par_bit;
              state <= PARITY;
            end else begin
              tx      <= shift_reg[1];
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        PARITY: begin
          if (wrap) begin
            tx       <= 1'b1;
            stop_cnt <= 1'b0;
            state    <= STOP;
          end
        end
        STOP: begin
          // Raised one cycle early so the pulse coincides with the last stop cycle.
          if (stop_cnt == STOP_LAST && baud_cnt == CNT_PRE) frame_done <= 1'b1;
          if (wrap) begin
            if (stop_cnt == STOP_LAST) state <= IDLE;
            else                       stop_cnt <= stop_cnt + 1'b1;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: two instances (1 stop bit / word parity,
// 2 stop bits / recomputed parity), each fed by a 1-cycle-latency FIFO model.
module tb_uart_tx_serializer;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       tx_en0, tx_en1;
  logic       fempty0 = 1'b1, fempty1 = 1'b1;
  logic [8:0] fdout0 = '0, fdout1 = '0;
  logic       rd_en0, tx0, busy0, fd0;
  logic       rd_en1, tx1, busy1, fd1;

  logic [8:0] fq0[$], fq1[$];
  logic [8:0] exp_q0[$], exp_q1[$];

  int cyc = 0;
  int cmp_cnt = 0;
  int err_cnt = 0;
  int pops[2], n_start[2], n_frames[2], n_abort[2];
  int pop_log[2][16], start_log[2][16], done_log[2][16];

  always #5 clk = ~clk;

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_SRC(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .tx_enable(tx_en0), .fifo_empty(fempty0),
    .fifo_dout(fdout0), .fifo_rd_en(rd_en0), .tx(tx0), .busy(busy0), .frame_done(fd0)
  );

  uart_tx_serializer #(.CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_SRC(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .tx_enable(tx_en1), .fifo_empty(fempty1),
    .fifo_dout(fdout1), .fifo_rd_en(rd_en1), .tx(tx1), .busy(busy1), .frame_done(fd1)
  );

  task automatic check(input string name, input int act, input int exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic get_tx(input int d);
    return (d == 0) ? tx0 : tx1;
  endfunction
  function automatic logic get_busy(input int d);
    return (d == 0) ? busy0 : busy1;
  endfunction
  function automatic logic get_fd(input int d);
    return (d == 0) ? fd0 : fd1;
  endfunction

  // FIFO model: registered read data, empty flag refreshed on the falling edge.
  always @(posedge clk) begin
    cyc++;
    if (rd_en0) begin
      check("d0_pop_nonempty", int'(fq0.size() > 0), 1);
      pop_log[0][pops[0] % 16] = cyc;
      pops[0]++;
      if (fq0.size() > 0) fdout0 <= fq0.pop_front();
    end
    if (rd_en1) begin
      check("d1_pop_nonempty", int'(fq1.size() > 0), 1);
      pop_log[1][pops[1] % 16] = cyc;
      pops[1]++;
      if (fq1.size() > 0) fdout1 <= fq1.pop_front();
    end
  end

  always @(negedge clk) begin
    fempty0 <= (fq0.size() == 0);
    fempty1 <= (fq1.size() == 0);
  end

  task automatic push(input int d, input logic [8:0] word, input logic [7:0] exp_data,
                      input logic exp_par);
    if (d == 0) begin
      fq0.push_back(word);
      exp_q0.push_back({exp_par, exp_data});
    end else begin
      fq1.push_back(word);
      exp_q1.push_back({exp_par, exp_data});
    end
  endtask

  // Monitor: reassembles each frame from tx and checks it against the scoreboard.
  task automatic monitor(input int d);
    int         len;
    int         b;
    int         fd_at;
    logic       prev;
    logic       have;
    logic       bad;
    logic       aborted;
    logic [8:0] e;
    logic [11:0] obs, expv;
    len  = (d == 0) ? 11 : 12;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev = 1'b1;
        continue;
      end
      if (get_fd(d)) check($sformatf("d%0d_spurious_frame_done", d), 1, 0);
      if (prev && !get_tx(d)) begin
        start_log[d][n_start[d] % 16] = cyc;
        n_start[d]++;
        e = '0;
        if (d == 0) begin
          have = (exp_q0.size() > 0);
          if (have) e = exp_q0.pop_front();
        end else begin
          have = (exp_q1.size() > 0);
          if (have) e = exp_q1.pop_front();
        end
        check($sformatf("d%0d_expected_available", d), int'(have), 1);
        obs = '1; bad = 1'b0; fd_at = -1; aborted = 1'b0;
        for (int k = 1; k <= len * CPB; k++) begin
          if (k > 1) @(negedge clk);
          if (!reset_n) begin
            aborted = 1'b1;
            break;
          end
          b = (k - 1) / CPB;
          if ((k - 1) % CPB == 0) obs[b] = get_tx(d);
          else if (get_tx(d) !== obs[b]) bad = 1'b1;
          if (!get_busy(d)) bad = 1'b1;
          if (get_fd(d)) begin
            if (fd_at < 0) begin
              fd_at = k;
              done_log[d][(n_start[d] - 1) % 16] = cyc;
            end else bad = 1'b1;
          end
        end
        if (aborted) begin
          n_abort[d]++;
          prev = 1'b1;
          continue;
        end
        expv      = '1;
        expv[0]   = 1'b0;
        expv[8:1] = e[7:0];
        expv[9]   = e[8];
        check($sformatf("d%0d_frame_bits", d), int'(obs), int'(expv));
        check($sformatf("d%0d_bit_timing", d), int'(bad), 0);
        check($sformatf("d%0d_frame_done_cycle", d), fd_at, len * CPB);
        @(negedge clk);
        check($sformatf("d%0d_post_frame_tx_busy_fd", d),
              int'({get_tx(d), get_busy(d), get_fd(d)}), 3'b100);
        n_frames[d]++;
      end
      prev = get_tx(d);
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  task automatic wait_frames(input int d, input int n, input int budget);
    int c = 0;
    while (n_frames[d] < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    check($sformatf("d%0d_frames_completed", d), n_frames[d], n);
  endtask

  task automatic wait_starts(input int d, input int n, input int budget);
    int c = 0;
    while (n_start[d] < n && c < budget) begin
      @(negedge clk);
      c++;
    end
    check($sformatf("d%0d_frames_started", d), n_start[d], n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0;
    tx_en0  = 1'b1;
    tx_en1  = 1'b1;
    push(0, 9'h1A5, 8'hA5, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    check("d0_reset_outputs", int'({tx0, busy0, rd_en0, fd0}), 4'b1000);
    check("d1_reset_outputs", int'({tx1, busy1, rd_en1, fd1}), 4'b1000);

    // Released with a word waiting but transmission disabled.
    tx_en0 = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("d0_disabled_no_pop", pops[0], 0);
    check("d0_disabled_tx_high", int'(tx0), 1);

    tx_en0 = 1'b1;
    wait_frames(0, 1, 100);
    check("d0_single_pop", pops[0], 1);
    check("d0_fall_after_pop_edge", start_log[0][0] - pop_log[0][0], 1);
    check("d0_frame_len", done_log[0][0] - start_log[0][0] + 1, 44);

    repeat (30) @(negedge clk);
    check("d0_empty_no_pop", pops[0], 1);
    check("d0_empty_tx_high", int'(tx0), 1);

    // Back-to-back.
    tx_en0 = 1'b0;
    push(0, 9'h055, 8'h55, 1'b0);
    push(0, 9'h0AA, 8'hAA, 1'b0);
    repeat (2) @(negedge clk);
    tx_en0 = 1'b1;
    wait_frames(0, 3, 200);
    check("d0_b2b_pops", pops[0], 3);
    check("d0_b2b_pop_spacing", pop_log[0][2] - pop_log[0][1], 46);
    check("d0_b2b_high_gap", start_log[0][2] - done_log[0][1] - 1, 2);

    // Enable dropped during DATA: frame completes, second word stays queued.
    tx_en0 = 1'b0;
    push(0, 9'h13C, 8'h3C, 1'b1);
    push(0, 9'h0C3, 8'hC3, 1'b0);
    repeat (2) @(negedge clk);
    tx_en0 = 1'b1;
    wait_starts(0, 4, 20);
    repeat (12) @(negedge clk);
    tx_en0 = 1'b0;
    wait_frames(0, 4, 100);
    repeat (50) @(negedge clk);
    check("d0_drop_enable_one_pop", pops[0], 4);

    // Reset mid-frame during data bit 3 of 0xC3 (tx low there).
    tx_en0 = 1'b1;
    wait_starts(0, 5, 20);
    repeat (17) @(negedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("d0_async_reset_outputs", int'({tx0, busy0, rd_en0, fd0}), 4'b1000);
    push(0, 9'h15A, 8'h5A, 1'b1);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    wait_frames(0, 5, 150);
    check("d0_fresh_pop_after_reset", pops[0], 6);
    check("d0_aborted_frames", n_abort[0], 1);

    // Recomputed parity with two stop bits.
    push(1, 9'h007, 8'h07, 1'b1);
    wait_frames(1, 1, 150);
    push(1, 9'h1FF, 8'hFF, 1'b0);
    wait_frames(1, 2, 150);
    tx_en1 = 1'b0;
    push(1, 9'h007, 8'h07, 1'b1);
    push(1, 9'h1FF, 8'hFF, 1'b0);
    repeat (2) @(negedge clk);
    tx_en1 = 1'b1;
    wait_frames(1, 4, 300);
    check("d1_pops", pops[1], 4);
    check("d1_b2b_pop_spacing", pop_log[1][3] - pop_log[1][2], 50);
    check("d1_b2b_high_gap", start_log[1][3] - done_log[1][2] - 1, 2);
    check("d1_frame_len", done_log[1][3] - start_log[1][3] + 1, 48);

    repeat (5) @(negedge clk);
    check("d0_scoreboard_drained", exp_q0.size(), 0);
    check("d1_scoreboard_drained", exp_q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
